// File: rtl/varint_pkg.sv
// varint_pkg: shared constants and state type for the varint encoder
// front-end arbiter.
package varint_pkg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 3;

    typedef enum logic [0:0] {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_e;

endpackage

// File: rtl/varint_rr_pick.sv
// varint_rr_pick: combinational round-robin picker. Finds the first set
// request at or above ptr, wrapping past NUM_REQ-1 back to 0.
module varint_rr_pick
    import varint_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx
);

    localparam logic [IDX_W:0] NREQ = (IDX_W + 1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;

    // Rotate requests so ptr lands at bit 0, pick the lowest set bit,
    // then add ptr back modulo NUM_REQ.
    always_comb begin
        dbl       = {req, req};
        rot       = NUM_REQ'(dbl >> ptr);
        off       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        sum       = {1'b0, ptr} + {1'b0, off};
        gnt_valid = |req;
        gnt_idx   = (sum >= NREQ) ? IDX_W'(sum - NREQ) : IDX_W'(sum);
    end

endmodule

// File: rtl/varint_arb.sv
// varint_arb: round-robin owner arbiter feeding the varint encoder FIFO.
// Define VARINT_ARB_STATS_EN to add per-requester grant counters (stat_grants).
module varint_arb
    import varint_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8,
    parameter int IDLE_TO   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_push,
    output logic [DATA_W-1:0]         fifo_data,
    output logic [IDX_W-1:0]          fifo_index,
    output logic                      busy,
    output logic [IDX_W-1:0]          owner
`ifdef VARINT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stat_grants
`endif
);

    localparam logic [7:0]       MAX_B8   = 8'(MAX_BURST);
    localparam logic [7:0]       IDLE8    = 8'(IDLE_TO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_e         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner_q;
    logic [7:0]         beat_cnt;
    logic [7:0]         idle_cnt;

    logic               gnt_valid;
    logic [IDX_W-1:0]   gnt_idx;

    logic               active;
    logic               sel_valid;
    logic               sel_last;
    logic [DATA_W-1:0]  sel_data;
    logic               xfer;
    logic [7:0]         beat_nxt;
    logic [7:0]         idle_nxt;
    logic               rel;
    logic [IDX_W-1:0]   ptr_nxt;

    varint_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Select the current owner's lane.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake, push path and release decision; reset masks everything
    // so an interrupted burst never pushes in the reset cycle.
    always_comb begin
        active   = (state == OWN) && !reset;
        xfer     = active && sel_valid && !fifo_full;
        beat_nxt = beat_cnt + 8'd1;
        idle_nxt = (idle_cnt == IDLE8) ? idle_cnt : idle_cnt + 8'd1;
        rel      = (xfer && (sel_last || beat_nxt == MAX_B8))
                || (active && !xfer && !sel_valid && idle_nxt == IDLE8);
        ptr_nxt  = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = active && !fifo_full && (owner_q == IDX_W'(i));
        end
        fifo_push  = xfer;
        fifo_data  = sel_data;
        fifo_index = owner_q;
        busy       = active;
        owner      = owner_q;
    end

    // Arbitration FSM and owner counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            rr_ptr   <= '0;
            owner_q  <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            unique case (state)
                ARB: begin
                    if (gnt_valid) begin
                        owner_q  <= gnt_idx;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (xfer) begin
                        beat_cnt <= beat_nxt;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_nxt;
                    end
                    if (rel) begin
                        state  <= ARB;
                        rr_ptr <= ptr_nxt;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

`ifdef VARINT_ARB_STATS_EN
    logic [15:0] grants [NUM_REQ];

    // Saturating grant counters, bumped on each ARB->OWN transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grants[i] <= '0;
            end
        end else if (state == ARB && gnt_valid) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_idx == IDX_W'(i) && grants[i] != 16'hFFFF) begin
                    grants[i] <= grants[i] + 16'd1;
                end
            end
        end
    end

    // Flatten counters onto the stats port.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*16 +: 16] = grants[i];
        end
    end
`endif

endmodule

// File: tb/tb_varint_arb.sv
// tb_varint_arb: directed self-checking bench for varint_arb with the
// default parameters (4 requesters, burst 8, idle timeout 4).
module tb_varint_arb;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*32-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_full = 1'b0;
    logic           fifo_push;
    logic [31:0]    fifo_data;
    logic [2:0]     fifo_index;
    logic           busy;
    logic [2:0]     owner;
`ifdef VARINT_ARB_STATS_EN
    logic [N*16-1:0] stat_grants;
`endif

    int total = 0;
    int bad = 0;

    // Per-requester beat sources and per-run logs.
    int          len [N];
    int          pos [N];
    int          plo [N];
    int          phi [N];
    logic [31:0] sdat [N][16];
    bit          slast [N][16];
    int          flo, fhi, rlo, rhi;
    int          lg_cyc [$];
    logic [2:0]  lg_idx [$];
    logic [31:0] lg_dat [$];
    bit          lg_busy [$];
    logic [N-1:0] lg_ready [$];

    varint_arb dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_push  (fifo_push),
        .fifo_data  (fifo_data),
        .fifo_index (fifo_index),
        .busy       (busy),
        .owner      (owner)
`ifdef VARINT_ARB_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    always #5 clk = ~clk;

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            len[i] = 0;
            pos[i] = 0;
            plo[i] = 0;
            phi[i] = 0;
            for (int k = 0; k < 16; k++) begin
                sdat[i][k] = '0;
                slast[i][k] = 1'b0;
            end
        end
        flo = 0; fhi = 0; rlo = 0; rhi = 0;
        lg_cyc.delete(); lg_idx.delete(); lg_dat.delete();
        lg_busy.delete(); lg_ready.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        req_last = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drive sources for n cycles; cycle c counts from the first cycle
    // after the call. Samples at the falling edge.
    task automatic run(input int n);
        logic [N-1:0] xv;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pos[i] < len[i]) begin
                    req_valid[i] = !(c >= plo[i] && c < phi[i]);
                    req_data[i*32 +: 32] = sdat[i][pos[i]];
                    req_last[i] = slast[i][pos[i]];
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[i*32 +: 32] = '0;
                    req_last[i] = 1'b0;
                end
            end
            fifo_full = (c >= flo && c < fhi);
            reset = (c >= rlo && c < rhi);
            @(negedge clk);
            xv = req_valid & req_ready;
            lg_busy.push_back(busy);
            lg_ready.push_back(req_ready);
            if (fifo_push) begin
                lg_cyc.push_back(c);
                lg_idx.push_back(fifo_index);
                lg_dat.push_back(fifo_data);
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (xv[i]) pos[i]++;
            end
        end
        req_valid = '0;
        req_last = '0;
        reset = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '1;
        req_last = '1;
        fifo_full = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rst_busy: got %b want 0", busy);
        end
        total++;
        if (fifo_push !== 1'b0) begin
            bad++; $display("FAIL rst_push: got %b want 0", fifo_push);
        end
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL rst_ready: got %b want 0000", req_ready);
        end
        total++;
        if (owner !== 3'd0) begin
            bad++; $display("FAIL rst_owner: got %0d want 0", owner);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || fifo_push !== 1'b0 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL post_rst: busy/push/ready got %b/%b/%b want 0/0/0000",
                     busy, fifo_push, req_ready);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || owner !== 3'd0 || fifo_push !== 1'b1) begin
            bad++;
            $display("FAIL first_grant: busy/owner/push got %b/%0d/%b want 1/0/1",
                     busy, owner, fifo_push);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        req_last = '0;
    endtask

    task automatic test_round_robin();
        int ec [5];
        logic [2:0] ei [5];
        logic [31:0] ed [5];
        clear_src();
        for (int i = 0; i < N; i++) begin
            len[i] = 2;
            for (int k = 0; k < 2; k++) begin
                sdat[i][k] = 32'hA0 + 32'(16 * i + k);
                slast[i][k] = 1'b1;
            end
        end
        ec = '{1, 3, 5, 7, 9};
        ei = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        ed = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hA1};
        do_reset();
        run(10);
        total++;
        if (lg_cyc.size() !== 5) begin
            bad++; $display("FAIL rr_count: got %0d want 5", lg_cyc.size());
        end
        for (int j = 0; j < 5 && j < lg_cyc.size(); j++) begin
            total++;
            if (lg_cyc[j] !== ec[j] || lg_idx[j] !== ei[j] || lg_dat[j] !== ed[j]) begin
                bad++;
                $display("FAIL rr_push%0d: cyc/idx/data got %0d/%0d/%h want %0d/%0d/%h",
                         j, lg_cyc[j], lg_idx[j], lg_dat[j], ec[j], ei[j], ed[j]);
            end
        end
    endtask

    task automatic test_short_msg();
        clear_src();
        len[2] = 3;
        sdat[2][0] = 32'h11;
        sdat[2][1] = 32'h22;
        sdat[2][2] = 32'h33;
        slast[2][2] = 1'b1;
        do_reset();
        run(6);
        total++;
        if (lg_cyc.size() !== 3) begin
            bad++; $display("FAIL msg_count: got %0d want 3", lg_cyc.size());
        end
        for (int j = 0; j < 3 && j < lg_cyc.size(); j++) begin
            total++;
            if (lg_cyc[j] !== j + 1 || lg_idx[j] !== 3'd2 || lg_dat[j] !== sdat[2][j]) begin
                bad++;
                $display("FAIL msg_push%0d: cyc/idx/data got %0d/%0d/%h want %0d/2/%h",
                         j, lg_cyc[j], lg_idx[j], lg_dat[j], j + 1, sdat[2][j]);
            end
        end
        total++;
        if (lg_busy[3] !== 1'b1 || lg_busy[4] !== 1'b0) begin
            bad++;
            $display("FAIL msg_busy_fall: c3/c4 got %b/%b want 1/0",
                     lg_busy[3], lg_busy[4]);
        end
    endtask

    task automatic test_preempt();
        int ec [14];
        logic [2:0] ei [14];
        logic [31:0] ed [14];
        clear_src();
        len[1] = 12;
        for (int k = 0; k < 12; k++) sdat[1][k] = 32'h100 + 32'(k);
        len[3] = 2;
        sdat[3][0] = 32'h300;
        sdat[3][1] = 32'h301;
        slast[3][1] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            ec[j] = j + 1; ei[j] = 3'd1; ed[j] = 32'h100 + 32'(j);
        end
        ec[8] = 10; ei[8] = 3'd3; ed[8] = 32'h300;
        ec[9] = 11; ei[9] = 3'd3; ed[9] = 32'h301;
        for (int j = 0; j < 4; j++) begin
            ec[10 + j] = 13 + j; ei[10 + j] = 3'd1; ed[10 + j] = 32'h108 + 32'(j);
        end
        do_reset();
        run(20);
        total++;
        if (lg_cyc.size() !== 14) begin
            bad++; $display("FAIL pre_count: got %0d want 14", lg_cyc.size());
        end
        for (int j = 0; j < 14 && j < lg_cyc.size(); j++) begin
            total++;
            if (lg_cyc[j] !== ec[j] || lg_idx[j] !== ei[j] || lg_dat[j] !== ed[j]) begin
                bad++;
                $display("FAIL pre_push%0d: cyc/idx/data got %0d/%0d/%h want %0d/%0d/%h",
                         j, lg_cyc[j], lg_idx[j], lg_dat[j], ec[j], ei[j], ed[j]);
            end
        end
        total++;
        if (lg_busy[9] !== 1'b0) begin
            bad++; $display("FAIL pre_bubble: busy got %b want 0", lg_busy[9]);
        end
    endtask

    task automatic test_idle_release();
        int ec [6];
        logic [2:0] ei [6];
        logic [31:0] ed [6];
        clear_src();
        len[0] = 4;
        for (int k = 0; k < 4; k++) sdat[0][k] = 32'hA0 + 32'(k);
        plo[0] = 3;
        phi[0] = 7;
        len[1] = 2;
        sdat[1][0] = 32'hB0;
        sdat[1][1] = 32'hB1;
        slast[1][1] = 1'b1;
        ec = '{1, 2, 8, 9, 11, 12};
        ei = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0};
        ed = '{32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hA2, 32'hA3};
        do_reset();
        run(16);
        total++;
        if (lg_busy[6] !== 1'b1 || lg_busy[7] !== 1'b0) begin
            bad++;
            $display("FAIL idle_release: busy c6/c7 got %b/%b want 1/0",
                     lg_busy[6], lg_busy[7]);
        end
        total++;
        if (lg_cyc.size() !== 6) begin
            bad++; $display("FAIL idle_count: got %0d want 6", lg_cyc.size());
        end
        for (int j = 0; j < 6 && j < lg_cyc.size(); j++) begin
            total++;
            if (lg_cyc[j] !== ec[j] || lg_idx[j] !== ei[j] || lg_dat[j] !== ed[j]) begin
                bad++;
                $display("FAIL idle_push%0d: cyc/idx/data got %0d/%0d/%h want %0d/%0d/%h",
                         j, lg_cyc[j], lg_idx[j], lg_dat[j], ec[j], ei[j], ed[j]);
            end
        end
    endtask

    task automatic test_fifo_stall();
        int ec [6];
        int nbusy;
        clear_src();
        len[2] = 6;
        for (int k = 0; k < 6; k++) sdat[2][k] = 32'h200 + 32'(k);
        slast[2][5] = 1'b1;
        flo = 3;
        fhi = 13;
        ec = '{1, 2, 13, 14, 15, 16};
        do_reset();
        run(19);
        total++;
        if (lg_cyc.size() !== 6) begin
            bad++; $display("FAIL stall_count: got %0d want 6", lg_cyc.size());
        end
        for (int j = 0; j < 6 && j < lg_cyc.size(); j++) begin
            total++;
            if (lg_cyc[j] !== ec[j] || lg_idx[j] !== 3'd2
                || lg_dat[j] !== 32'h200 + 32'(j)) begin
                bad++;
                $display("FAIL stall_push%0d: cyc/idx/data got %0d/%0d/%h want %0d/2/%h",
                         j, lg_cyc[j], lg_idx[j], lg_dat[j], ec[j], 32'h200 + 32'(j));
            end
        end
        nbusy = 0;
        for (int c = 3; c < 13; c++) if (lg_busy[c]) nbusy++;
        total++;
        if (nbusy !== 10) begin
            bad++; $display("FAIL stall_hold: busy cycles got %0d want 10", nbusy);
        end
        total++;
        if (lg_ready[5] !== 4'b0000) begin
            bad++; $display("FAIL stall_ready: got %b want 0000", lg_ready[5]);
        end
        total++;
        if (lg_busy[17] !== 1'b0) begin
            bad++; $display("FAIL stall_end: busy got %b want 0", lg_busy[17]);
        end
    endtask

    task automatic test_reset_mid();
        int ec [5];
        logic [2:0] ei [5];
        logic [31:0] ed [5];
        clear_src();
        len[2] = 1;
        sdat[2][0] = 32'h20;
        slast[2][0] = 1'b1;
        len[3] = 6;
        for (int k = 0; k < 6; k++) sdat[3][k] = 32'h300 + 32'(k);
        len[1] = 6;
        for (int k = 0; k < 6; k++) sdat[1][k] = 32'h100 + 32'(k);
        plo[1] = 0;
        phi[1] = 6;
        rlo = 5;
        rhi = 6;
        ec = '{1, 3, 4, 7, 8};
        ei = '{3'd2, 3'd3, 3'd3, 3'd1, 3'd1};
        ed = '{32'h20, 32'h300, 32'h301, 32'h100, 32'h101};
        do_reset();
        run(9);
        total++;
        if (lg_busy[5] !== 1'b0 || lg_busy[6] !== 1'b0) begin
            bad++;
            $display("FAIL midrst_busy: c5/c6 got %b/%b want 0/0",
                     lg_busy[5], lg_busy[6]);
        end
        total++;
        if (lg_cyc.size() !== 5) begin
            bad++; $display("FAIL midrst_count: got %0d want 5", lg_cyc.size());
        end
        for (int j = 0; j < 5 && j < lg_cyc.size(); j++) begin
            total++;
            if (lg_cyc[j] !== ec[j] || lg_idx[j] !== ei[j] || lg_dat[j] !== ed[j]) begin
                bad++;
                $display("FAIL midrst_push%0d: cyc/idx/data got %0d/%0d/%h want %0d/%0d/%h",
                         j, lg_cyc[j], lg_idx[j], lg_dat[j], ec[j], ei[j], ed[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_short_msg();
        test_preempt();
        test_idle_release();
        test_fifo_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
